// File: rtl/vis_byte_framer_pkg.sv
`default_nettype none
//==============================================================================
// Module: vis_byte_framer_pkg -- constants and FSM encoding for the byte framer
// Revision: 1.0
//==============================================================================
package vis_byte_framer_pkg;

    localparam int         C_ACCUM = 32;
    localparam logic [7:0] C_MAGIC = 8'hA5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HDR_MAGIC = 2'd1,
        HDR_SEQ   = 2'd2,
        DATA      = 2'd3
    } state_t;

    function automatic int nbytes(input int accum);
        return (2 * accum) / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vis_byte_framer_if.sv
`default_nettype none
//==============================================================================
// Module: vis_byte_framer_if -- visibility word input and byte output streams
// Revision: 1.0
//==============================================================================
interface vis_byte_framer_if #(
    parameter int ACCUM = 32
);
    logic             s_valid_i;
    logic             s_ready_o;
    logic             s_last_i;
    logic [ACCUM-1:0] s_revis_i;
    logic [ACCUM-1:0] s_imvis_i;
    logic             m_valid_o;
    logic             m_ready_i;
    logic             m_last_o;
    logic [7:0]       m_data_o;
    logic [7:0]       seq_o;

    modport slave (
        input  s_valid_i, s_last_i, s_revis_i, s_imvis_i, m_ready_i,
        output s_ready_o, m_valid_o, m_last_o, m_data_o, seq_o
    );

    modport master (
        output s_valid_i, s_last_i, s_revis_i, s_imvis_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_last_o, m_data_o, seq_o
    );
endinterface
`default_nettype wire

// File: rtl/vis_byte_framer_axis_skid.sv
`default_nettype none
//==============================================================================
// Module: axis_skid -- single-entry AXI-Stream hold register, registered ready
// Revision: 1.0
//==============================================================================
module axis_skid #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_valid,
    output logic                  o_ready,
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data,
    input  wire logic             i_pop
);

    logic             r_full;
    logic             r_ready;
    logic [WIDTH-1:0] r_data;
    logic             w_push;
    logic             w_full_next;

    assign w_push      = i_valid && r_ready;
    assign w_full_next = w_push || (r_full && !i_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full  <= 1'b0;
            r_ready <= 1'b0;
            r_data  <= '0;
        end else begin
            r_full  <= w_full_next;
            r_ready <= !w_full_next;
            if (w_push) begin
                r_data <= i_data;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_full;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/vis_byte_framer.sv
`default_nettype none
//==============================================================================
// Module: vis_byte_framer -- 64-bit visibility words to framed 8-bit stream
// Revision: 1.0
//==============================================================================
module vis_byte_framer
    import vis_byte_framer_pkg::*;
#(
    parameter int         ACCUM  = C_ACCUM,
    parameter logic [7:0] MAGIC  = C_MAGIC,
    parameter bit         HEADER = 1'b1
) (
    input  wire logic         clock,
    input  wire logic         reset,
    vis_byte_framer_if.slave  bus
);

    localparam int NB = nbytes(ACCUM);
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;

    logic                 w_hold_valid;
    logic [2*ACCUM:0]     w_hold_data;
    logic [2*ACCUM-1:0]   w_hold_vec;
    logic                 w_hold_last;
    logic                 w_pop;
    logic                 w_accept;
    logic                 w_last_byte;
    logic                 w_sof_next;
    logic                 w_sof_go;
    logic [KW-1:0]        w_k_inc;

    state_t               r_state;
    logic [2*ACCUM-1:0]   r_word;
    logic                 r_wlast;
    logic [KW-1:0]        r_k;
    logic                 r_sof;
    logic [7:0]           r_seq;
    logic                 r_m_valid;
    logic                 r_m_last;
    logic [7:0]           r_m_data;

    axis_skid #(
        .WIDTH (2*ACCUM + 1)
    ) u_skid (
        .clk     (clock),
        .rst     (reset),
        .i_valid (bus.s_valid_i),
        .o_ready (bus.s_ready_o),
        .i_data  ({bus.s_last_i, bus.s_imvis_i, bus.s_revis_i}),
        .o_valid (w_hold_valid),
        .o_data  (w_hold_data),
        .i_pop   (w_pop)
    );

    // Word vector is {imvis, revis}, so ascending byte index gives revis LSB first.
    assign w_hold_vec  = w_hold_data[2*ACCUM-1:0];
    assign w_hold_last = w_hold_data[2*ACCUM];
    assign w_accept    = r_m_valid && bus.m_ready_i;
    assign w_last_byte = (r_k == KW'(NB - 1));
    assign w_k_inc     = r_k + 1'b1;
    assign w_sof_next  = r_sof || r_wlast;
    assign w_sof_go    = (r_state == IDLE) ? r_sof : w_sof_next;
    assign w_pop       = w_hold_valid &&
                         ((r_state == IDLE) || ((r_state == DATA) && w_accept && w_last_byte));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_word    <= '0;
            r_wlast   <= 1'b0;
            r_k       <= '0;
            r_sof     <= 1'b1;
            r_seq     <= 8'd0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= 8'd0;
        end else begin
            if ((r_state == DATA) && w_accept && w_last_byte && r_wlast) begin
                r_seq <= r_seq + 8'd1;
            end
            // Loading from hold covers both the IDLE start and the no-bubble reload.
            if (w_pop) begin
                r_word    <= w_hold_vec;
                r_wlast   <= w_hold_last;
                r_k       <= '0;
                r_sof     <= 1'b0;
                r_m_valid <= 1'b1;
                r_m_last  <= 1'b0;
                if (w_sof_go && HEADER) begin
                    r_state  <= HDR_MAGIC;
                    r_m_data <= MAGIC;
                end else begin
                    r_state  <= DATA;
                    r_m_data <= w_hold_vec[7:0];
                end
            end else begin
                case (r_state)
                    HDR_MAGIC: begin
                        if (w_accept) begin
                            r_state  <= HDR_SEQ;
                            r_m_data <= r_seq;
                        end
                    end
                    HDR_SEQ: begin
                        if (w_accept) begin
                            r_state  <= DATA;
                            r_k      <= '0;
                            r_m_data <= r_word[7:0];
                            r_m_last <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (w_accept) begin
                            if (w_last_byte) begin
                                r_state   <= IDLE;
                                r_m_valid <= 1'b0;
                                r_m_last  <= 1'b0;
                                r_sof     <= w_sof_next;
                            end else begin
                                r_k      <= w_k_inc;
                                r_m_data <= r_word[{w_k_inc, 3'b000} +: 8];
                                r_m_last <= r_wlast && (w_k_inc == KW'(NB - 1));
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.m_valid_o = r_m_valid;
    assign bus.m_last_o  = r_m_last;
    assign bus.m_data_o  = r_m_data;
    assign bus.seq_o     = r_seq;

endmodule
`default_nettype wire

// File: tb/tb_vis_byte_framer.sv
`default_nettype none
//==============================================================================
// Module: tb_vis_byte_framer -- randomized scoreboard bench for vis_byte_framer
// Revision: 1.0
//==============================================================================
module tb_vis_byte_framer;

    logic clock;
    logic reset;
    logic m_ready;
    int   rdy_mode;
    int   total;
    int   bad;
    int   cyc;

    logic [8:0] got_q[$];
    logic [8:0] got0_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] exp0_q[$];
    int         got_cyc[$];
    logic [7:0] m_seq;
    bit         m_sof;

    logic       pv;
    logic       pr;
    logic       pl;
    logic [7:0] pd;

    vis_byte_framer_if #(.ACCUM(32)) bus ();
    vis_byte_framer_if #(.ACCUM(32)) bus0 ();

    vis_byte_framer #(.ACCUM(32), .MAGIC(8'hA5), .HEADER(1'b1)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    vis_byte_framer #(.ACCUM(32), .MAGIC(8'hA5), .HEADER(1'b0)) u_dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0.slave)
    );

    assign bus.m_ready_i  = m_ready;
    assign bus0.m_ready_i = m_ready;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    always @(posedge clock) begin
        #1;
        if (rdy_mode == 0) m_ready = 1'b1;
        else if (rdy_mode == 1) m_ready = 1'($urandom_range(0, 1));
    end

    // Collect accepted bytes; also enforce AXI hold-stable while stalled.
    always @(negedge clock) begin
        if (reset) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                total = total + 1;
                if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== pd || bus.m_last_o !== pl) begin
                    bad = bad + 1;
                    $display("FAIL hold_stable got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                             bus.m_valid_o, bus.m_data_o, bus.m_last_o, pd, pl);
                end
            end
            if (bus.m_valid_o && m_ready) begin
                got_q.push_back({bus.m_last_o, bus.m_data_o});
                got_cyc.push_back(cyc);
            end
            if (bus0.m_valid_o && m_ready) got0_q.push_back({bus0.m_last_o, bus0.m_data_o});
            pv = bus.m_valid_o; pr = m_ready; pd = bus.m_data_o; pl = bus.m_last_o;
        end
    end

    // Reference: header (MAGIC, seq) at frame start, then revis bytes LSB first, then imvis.
    function automatic void model_word(input bit sel, input logic [31:0] re,
                                       input logic [31:0] im, input bit last);
        logic [63:0] v;
        v = {im, re};
        if (!sel && m_sof) begin
            exp_q.push_back({1'b0, 8'hA5});
            exp_q.push_back({1'b0, m_seq});
        end
        for (int i = 0; i < 8; i++) begin
            if (sel) exp0_q.push_back({last && (i == 7), v[8*i +: 8]});
            else     exp_q.push_back({last && (i == 7), v[8*i +: 8]});
        end
        if (!sel) begin
            m_sof = last;
            if (last) m_seq = m_seq + 8'd1;
        end
    endfunction

    task automatic send_word(input bit sel, input logic [31:0] re, input logic [31:0] im,
                             input bit last);
        int n;
        n = 0;
        model_word(sel, re, im, last);
        if (sel) begin
            bus0.s_valid_i = 1'b1; bus0.s_revis_i = re; bus0.s_imvis_i = im; bus0.s_last_i = last;
        end else begin
            bus.s_valid_i = 1'b1; bus.s_revis_i = re; bus.s_imvis_i = im; bus.s_last_i = last;
        end
        do begin
            @(negedge clock);
            n++;
        end while (!(sel ? bus0.s_ready_o : bus.s_ready_o) && n < 400);
        total = total + 1;
        if (n >= 400) begin
            bad = bad + 1;
            $display("FAIL s_ready_timeout got=0 exp=1");
        end
        @(posedge clock); #1;
        if (sel) bus0.s_valid_i = 1'b0;
        else     bus.s_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input bit sel, input int budget);
        int n;
        n = 0;
        while ((sel ? got0_q.size() < exp0_q.size() : got_q.size() < exp_q.size()) && n < budget) begin
            @(posedge clock);
            n++;
        end
        repeat (12) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        m_seq = 8'd0; m_sof = 1'b1;
        got_q.delete(); got0_q.delete(); got_cyc.delete(); exp_q.delete(); exp0_q.delete();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        @(negedge clock);
        total = total + 5;
        if (bus.m_valid_o !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b exp=0", bus.m_valid_o); end
        if (bus.m_last_o !== 1'b0) begin bad++; $display("FAIL rst_m_last got=%b exp=0", bus.m_last_o); end
        if (bus.m_data_o !== 8'h00) begin bad++; $display("FAIL rst_m_data got=%h exp=00", bus.m_data_o); end
        if (bus.s_ready_o !== 1'b0) begin bad++; $display("FAIL rst_s_ready got=%b exp=0", bus.s_ready_o); end
        if (bus.seq_o !== 8'h00) begin bad++; $display("FAIL rst_seq got=%h exp=00", bus.seq_o); end
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (bus.s_ready_o !== 1'b0) begin bad++; $display("FAIL rdy_before_edge got=%b exp=0", bus.s_ready_o); end
        @(posedge clock); #1;
        total++;
        if (bus.s_ready_o !== 1'b1) begin bad++; $display("FAIL rdy_after_edge got=%b exp=1", bus.s_ready_o); end
    endtask

    task automatic test_single_word();
        rdy_mode = 0;
        send_word(1'b0, 32'h04030201, 32'h08070605, 1'b1);
        wait_drain(1'b0, 200);
        total++;
        if (got_q.size() != 10) begin bad++; $display("FAIL single_len got=%0d exp=10", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL single_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        total++;
        if (bus.seq_o !== 8'd1) begin bad++; $display("FAIL single_seq got=%h exp=01", bus.seq_o); end
        got_q.delete(); exp_q.delete(); got_cyc.delete();
    endtask

    task automatic test_back_to_back();
        do_reset();
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) send_word(1'b0, $urandom, $urandom, i == 2);
        for (int i = 0; i < 2; i++) send_word(1'b0, $urandom, $urandom, i == 1);
        wait_drain(1'b0, 300);
        total++;
        if (got_q.size() != 44) begin bad++; $display("FAIL b2b_len got=%0d exp=44", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() == 44) begin
            total = total + 2;
            if (got_q[27] !== 9'h001) begin bad++; $display("FAIL b2b_seq2 got=%h exp=001", got_q[27]); end
            if (got_cyc[43] - got_cyc[0] != 43) begin
                bad++; $display("FAIL b2b_gap got=%0d exp=43", got_cyc[43] - got_cyc[0]);
            end
        end
        got_q.delete(); exp_q.delete(); got_cyc.delete();
    endtask

    task automatic test_ready_pulse();
        logic [7:0] s;
        rdy_mode = 2; m_ready = 1'b0;
        s = m_seq;
        send_word(1'b0, $urandom, $urandom, 1'b1);
        repeat (4) @(posedge clock);
        #1;
        total = total + 2;
        if (bus.m_valid_o !== 1'b1) begin bad++; $display("FAIL pulse_valid got=%b exp=1", bus.m_valid_o); end
        if (bus.m_data_o !== 8'hA5) begin bad++; $display("FAIL pulse_magic got=%h exp=a5", bus.m_data_o); end
        m_ready = 1'b1;
        @(posedge clock); #1;
        m_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        total = total + 2;
        if (got_q.size() != 1) begin bad++; $display("FAIL pulse_count got=%0d exp=1", got_q.size()); end
        if (bus.m_data_o !== s) begin bad++; $display("FAIL pulse_seq got=%h exp=%h", bus.m_data_o, s); end
        rdy_mode = 0;
        wait_drain(1'b0, 200);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL pulse_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL pulse_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete(); got_cyc.delete();
    endtask

    task automatic test_no_header();
        rdy_mode = 0;
        send_word(1'b1, 32'h14131211, 32'h18171615, 1'b0);
        send_word(1'b1, 32'h24232221, 32'h28272625, 1'b1);
        wait_drain(1'b1, 200);
        total++;
        if (got0_q.size() != 16) begin bad++; $display("FAIL nohdr_len got=%0d exp=16", got0_q.size()); end
        foreach (exp0_q[i]) if (i < got0_q.size()) begin
            total++;
            if (got0_q[i] !== exp0_q[i]) begin bad++; $display("FAIL nohdr_byte[%0d] got=%h exp=%h", i, got0_q[i], exp0_q[i]); end
        end
        got0_q.delete(); exp0_q.delete();
    endtask

    task automatic test_random();
        int left;
        left = 0;
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            if (left == 0) left = $urandom_range(1, 5);
            left--;
            send_word(1'b0, $urandom, $urandom, (left == 0) || (i == 999));
            if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
        end
        wait_drain(1'b0, 40000);
        rdy_mode = 0;
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        total++;
        if (bus.seq_o !== m_seq) begin bad++; $display("FAIL rand_seq got=%h exp=%h", bus.seq_o, m_seq); end
        got_q.delete(); exp_q.delete(); got_cyc.delete();
    endtask

    task automatic test_seq_wrap();
        do_reset();
        rdy_mode = 0;
        for (int f = 0; f < 257; f++) send_word(1'b0, $urandom, $urandom, 1'b1);
        wait_drain(1'b0, 8000);
        total++;
        if (got_q.size() != 2570) begin bad++; $display("FAIL wrap_len got=%0d exp=2570", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() == 2570) begin
            total = total + 2;
            if (got_q[2551] !== 9'h0FF) begin bad++; $display("FAIL wrap_seq255 got=%h exp=0ff", got_q[2551]); end
            if (got_q[2561] !== 9'h000) begin bad++; $display("FAIL wrap_seq256 got=%h exp=000", got_q[2561]); end
        end
        total++;
        if (bus.seq_o !== 8'd1) begin bad++; $display("FAIL wrap_seq_o got=%h exp=01", bus.seq_o); end
        got_q.delete(); exp_q.delete(); got_cyc.delete();
    endtask

    task automatic test_reset_mid();
        int n;
        rdy_mode = 0;
        n = 0;
        send_word(1'b0, 32'h44332211, 32'h88776655, 1'b1);
        while (got_q.size() < 5 && n < 100) begin @(posedge clock); #1; n++; end
        total++;
        if (got_q.size() != 5) begin bad++; $display("FAIL mid_progress got=%0d exp=5", got_q.size()); end
        reset = 1'b1;
        #1;
        total = total + 2;
        if (bus.m_valid_o !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", bus.m_valid_o); end
        if (bus.seq_o !== 8'd0) begin bad++; $display("FAIL mid_seq got=%h exp=00", bus.seq_o); end
        got_q.delete(); exp_q.delete(); got_cyc.delete();
        m_seq = 8'd0; m_sof = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        total++;
        if (got_q.size() != 0) begin bad++; $display("FAIL mid_stale got=%0d exp=0", got_q.size()); end
        send_word(1'b0, 32'hCAFEF00D, 32'h12345678, 1'b1);
        wait_drain(1'b0, 200);
        total++;
        if (got_q.size() != 10) begin bad++; $display("FAIL mid_len got=%0d exp=10", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL mid_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0; bad = 0; cyc = 0;
        reset = 1'b0; m_ready = 1'b1; rdy_mode = 0;
        m_seq = 8'd0; m_sof = 1'b1;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 8'd0;
        bus.s_valid_i = 1'b0; bus.s_last_i = 1'b0; bus.s_revis_i = '0; bus.s_imvis_i = '0;
        bus0.s_valid_i = 1'b0; bus0.s_last_i = 1'b0; bus0.s_revis_i = '0; bus0.s_imvis_i = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_ready_pulse();
        test_no_header();
        test_random();
        test_seq_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
